// File: rtl/cordic_pkg.sv
// Shared constants for the sequential CORDIC rotator: Q8.12 scalars,
// FSM state encodings and the arctangent table.
package cordic_pkg;

    localparam int unsigned DW         = 20;
    localparam int unsigned FRAC       = 12;
    localparam int unsigned N_ITER_MAX = 16;

    localparam logic        [DW-1:0] K       = 20'h009B8;
    localparam logic signed [DW-1:0] PI      = 20'sd12868;
    localparam logic signed [DW-1:0] HALF_PI = 20'sd6434;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ITER  = 2'd1;
    localparam state_t ST_SCALE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // atan(2^-i) in Q8.12, rounded to nearest
    localparam logic signed [DW-1:0] ATAN [N_ITER_MAX] = '{
        20'sd3217, 20'sd1899, 20'sd1003, 20'sd509,
        20'sd256,  20'sd128,  20'sd64,   20'sd32,
        20'sd16,   20'sd8,    20'sd4,    20'sd2,
        20'sd1,    20'sd1,    20'sd0,    20'sd0
    };

endpackage

// File: rtl/cordic_iter_stage.sv
// One CORDIC micro-rotation; purely combinational, reused every ITER cycle.
module cordic_iter_stage
    import cordic_pkg::*;
(
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [DW-1:0] z_i,
    input  logic        [3:0]    i_i,
    input  logic signed [DW-1:0] atan_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [DW-1:0] z_o
);

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;
    logic                 rot_pos;

    assign x_sh    = x_i >>> i_i;
    assign y_sh    = y_i >>> i_i;
    assign rot_pos = ~z_i[DW-1];

    always_comb begin
        if (rot_pos) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end

endmodule

// File: rtl/cordic_seq.sv
// Sequential rotation-mode CORDIC: one micro-rotation per clock, then a
// gain-compensation step, with a valid/ready handshake on both sides.
module cordic_seq #(
    parameter int unsigned N_ITER = 16,
    parameter int unsigned FRAC   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [19:0] x_in,
    input  logic signed [19:0] y_in,
    input  logic signed [19:0] angle_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [19:0] x_out,
    output logic signed [19:0] y_out,
    output logic               busy
);

    import cordic_pkg::*;

    state_t               state_q, state_d;
    logic        [3:0]    i_q, i_d;
    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] y_q, y_d;
    logic signed [DW-1:0] z_q, z_d;
    logic signed [DW-1:0] xo_q, xo_d;
    logic signed [DW-1:0] yo_q, yo_d;

    logic signed [DW-1:0]   x_nx, y_nx, z_nx;
    logic signed [2*DW-1:0] x_prod, y_prod;
    logic                   last_iter;

    cordic_iter_stage u_stage (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .i_i    (i_q),
        .atan_i (ATAN[i_q]),
        .x_o    (x_nx),
        .y_o    (y_nx),
        .z_o    (z_nx)
    );

    assign last_iter = (i_q == 4'(N_ITER - 1));
    assign x_prod    = x_q * $signed(K);
    assign y_prod    = y_q * $signed(K);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Fold angles beyond +/-pi/2 into CORDIC's convergence range
                    if (angle_in > HALF_PI) begin
                        x_d = -x_in;
                        y_d = -y_in;
                        z_d = angle_in - PI;
                    end else if (angle_in < -HALF_PI) begin
                        x_d = -x_in;
                        y_d = -y_in;
                        z_d = angle_in + PI;
                    end else begin
                        x_d = x_in;
                        y_d = y_in;
                        z_d = angle_in;
                    end
                    i_d     = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                x_d = x_nx;
                y_d = y_nx;
                z_d = z_nx;
                if (last_iter) begin
                    state_d = ST_SCALE;
                end else begin
                    i_d = i_q + 4'd1;
                end
            end
            ST_SCALE: begin
                xo_d    = DW'(x_prod >>> FRAC);
                yo_d    = DW'(y_prod >>> FRAC);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign x_out     = xo_q;
    assign y_out     = yo_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Directed and swept checks of cordic_seq: handshake timing, pre-rotation,
// backpressure, reset abort and numeric accuracy.
module tb_cordic_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [19:0] x_in, y_in, angle_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] x_out, y_out;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    cordic_seq #(.N_ITER(16), .FRAC(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int diff;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        n_vec++;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept edge counts as edge 1; returns the edge count at which out_valid is seen.
    task automatic run_op(input int xi, input int yi, input int ai,
                          output int xo, output int yo, output int lat);
        x_in     = 20'(xi);
        y_in     = 20'(yi);
        angle_in = 20'(ai);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x_in     = 20'h5A5A5;
        y_in     = 20'hA5A5A;
        angle_in = 20'h01234;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        xo = int'(x_out);
        yo = int'(y_out);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // x_in, y_in, angle_in, expected x, expected y, tolerance
    int dv [8][6] = '{
        '{4096,    0,      0,  4096,     0, 4},
        '{4096,    0,   6434,     0,  4096, 4},
        '{4096,    0, -12868, -4096,     0, 4},
        '{4096,    0,  -6434,     0, -4096, 4},
        '{4096,    0,  12868, -4096,     0, 4},
        '{4096,    0,   3217,  2896,  2896, 4},
        '{4096,    0,  10000, -3132,  2639, 8},
        '{   0, 4096,   6435, -4096,    -1, 4}
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xo, yo, lat, cnt, prev, gap, a, ex, ey;
        real ar;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; angle_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready",  int'(in_ready),  1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_busy",      int'(busy),      0, 0);
        chk("rst_x_out",     int'(x_out),     0, 0);
        chk("rst_y_out",     int'(y_out),     0, 0);

        for (int k = 0; k < 8; k++) begin
            run_op(dv[k][0], dv[k][1], dv[k][2], xo, yo, lat);
            chk($sformatf("dir%0d_lat", k), lat, 18, 0);
            chk($sformatf("dir%0d_x", k), xo, dv[k][3], dv[k][5]);
            chk($sformatf("dir%0d_y", k), yo, dv[k][4], dv[k][5]);
            consume();
        end

        run_op(4096, 0, 3217, xo, yo, lat);
        chk("bp_lat", lat, 18, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_x_hold",   int'(x_out),     xo, 0);
            chk("bp_y_hold",   int'(y_out),     yo, 0);
            chk("bp_valid",    int'(out_valid), 1,  0);
            chk("bp_in_ready", int'(in_ready),  0,  0);
        end
        consume();
        chk("bp_release_in_ready", int'(in_ready),  1, 0);
        chk("bp_release_valid",    int'(out_valid), 0, 0);

        x_in = 20'sd4096; y_in = '0; angle_in = '0;
        in_valid = 1'b1;
        tick();
        lat = 1;
        in_valid = 1'b0;
        repeat (4) begin tick(); lat++; end
        in_valid = 1'b1; out_ready = 1'b1;
        x_in = '0; y_in = 20'sd4096; angle_in = 20'sd6434;
        tick(); lat++;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ign_busy",     int'(busy),     1, 0);
        chk("ign_in_ready", int'(in_ready), 0, 0);
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("ign_lat", lat, 18, 0);
        chk("ign_x", int'(x_out), 4096, 4);
        chk("ign_y", int'(y_out), 0,    4);
        consume();
        cnt = 0;
        repeat (30) begin tick(); if (out_valid) cnt++; end
        chk("ign_extra_results", cnt, 0, 0);
        chk("ign_idle", int'(in_ready), 1, 0);

        x_in = 20'sd4096; y_in = '0; angle_in = 20'sd6434;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_x_out",    int'(x_out),     0, 0);
        chk("abort_y_out",    int'(y_out),     0, 0);
        chk("abort_valid",    int'(out_valid), 0, 0);
        chk("abort_busy",     int'(busy),      0, 0);
        chk("abort_in_ready", int'(in_ready),  1, 0);
        cnt = 0;
        repeat (30) begin tick(); if (out_valid) cnt++; end
        chk("abort_no_result", cnt, 0, 0);
        run_op(4096, 0, 3217, xo, yo, lat);
        chk("after_abort_lat", lat, 18, 0);
        chk("after_abort_x", xo, 2896, 4);
        chk("after_abort_y", yo, 2896, 4);

        out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_done_valid",    int'(out_valid), 0, 0);
        chk("rst_done_in_ready", int'(in_ready),  1, 0);
        chk("rst_done_x_out",    int'(x_out),     0, 0);

        out_ready = 1'b1; in_valid = 1'b1;
        x_in = 20'sd4096; y_in = '0; angle_in = '0;
        prev = -1; gap = -1;
        for (int c = 0; c < 60; c++) begin
            if (in_ready) begin
                if (prev >= 0 && gap < 0) gap = c - prev;
                prev = c;
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (25) tick();
        out_ready = 1'b0;
        chk("init_interval", gap, 19, 0);

        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(25736)) - 12868;
            run_op(2000, -1500, a, xo, yo, lat);
            ar = real'(a) / 4096.0;
            ex = int'(2000.0 * $cos(ar) + 1500.0 * $sin(ar));
            ey = int'(2000.0 * $sin(ar) - 1500.0 * $cos(ar));
            chk($sformatf("sweep%0d_a%0d_x", k, a), xo, ex, 8);
            chk($sformatf("sweep%0d_a%0d_y", k, a), yo, ey, 8);
            consume();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 Parameters, one per line: N_ITER, 16, number of micro-rotations (1..16) | FRAC, 12, fractional bits of all data words (Q8.12 two's complement).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  request presents x_in/y_in/angle_in.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 x_in, y_in  input  20 each  signed Q8.12 start vector.
REQ-008 angle_in  input  20  signed Q8.12 rotation angle in radians; legal range [-PI, +PI].
REQ-009 out_valid  output  1  x_out/y_out hold a result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 x_out, y_out  output  20 each  signed Q8.12 rotated, gain-compensated vector.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ITER, SCALE, DONE.
REQ-014 in_ready SHALL be high only in IDLE; a request is accepted on an edge with in_valid && in_ready.
REQ-015 On acceptance: if angle_in > HALF_PI, load x=-x_in, y=-y_in, z=angle_in-PI; if angle_in < -HALF_PI, load x=-x_in, y=-y_in, z=angle_in+PI; otherwise load unchanged. Then clear iteration counter i=0 and go to ITER.
REQ-016 In ITER, each edge: d=+1 if z>=0, else -1; x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*ATAN[i]. Shifts are arithmetic; add/sub wraps at 20 bits.
REQ-017 ITER SHALL last exactly N_ITER edges (i=0..N_ITER-1), then go to SCALE.
REQ-018 SCALE SHALL compute x_out=(x*K)>>>FRAC and y_out=(y*K)>>>FRAC with a 40-bit signed product, truncation toward -inf, low 20 bits kept. It registers both outputs and goes to DONE.
REQ-019 Latency: out_valid SHALL be high after the (N_ITER+2)th rising edge following the accepting edge, i.e. 18 edges for N_ITER=16.
REQ-020 In DONE, out_valid=1 and x_out/y_out SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-021 No new request is accepted in the DONE->IDLE edge; minimum initiation interval is N_ITER+3 edges.
REQ-022 in_valid is ignored outside IDLE; input signals are sampled only on the accepting edge.
REQ-023 angle_in = +/-HALF_PI exactly SHALL take the no-pre-rotation path.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 On rst=1: state=IDLE, i=0, x/y/z=0, x_out=y_out=0, out_valid=0, busy=0, and in_ready=1 from the next cycle.
REQ-026 rst SHALL win over every handshake on the same edge; reset mid-ITER or in DONE discards the operation with no out_valid pulse.

Structure
REQ-027 Package cordic_pkg SHALL hold FRAC=12, K=20'h009B8, PI=12868, HALF_PI=6434, N_ITER_MAX=16, the state enum, and the ATAN[0..15] table. The ATAN values are round-to-nearest Q8.12: 3217,1899,1003,509,256,128,64,32,16,8,4,2,1,1,0,0.
REQ-028 The single-iteration datapath of REQ-016 SHALL be one combinational sub-module, cordic_iter_stage (x, y, z, i, atan in; x', y', z' out), instanced once and time-multiplexed.

Verification
REQ-029 x_in=4096, y_in=0, angle_in=0 -> out_valid at edge 18; x_out within 4096+/-4, y_out within 0+/-4.
REQ-030 x_in=4096, y_in=0, angle_in=6434 -> x_out within 0+/-4, y_out within 4096+/-4. Repeat with angle_in=-12868 -> x_out within -4096+/-4, y_out within 0+/-4 (pre-rotation path).
REQ-031 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1.
REQ-032 Second in_valid pulse during ITER -> ignored; exactly one result is produced.
REQ-033 rst pulse at ITER i=7 -> next cycle all outputs 0, in_ready=1, no out_valid. A new request then completes normally.
REQ-034 Randomized sweep: 1000 angles in [-PI, PI] against a real-valued model; |error| <= 8 LSB per component.
